// File: rtl/top.sv
// Registered multi-lane datapath: sum, difference, accumulator, rotator, counter and status flags.
// Optional build macro ACC_SAT_EN makes the accumulator saturate instead of wrap.
module top (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [135:0] in_flat,
   output logic [158:0] out_flat
);

   logic [31:0] a, b, c, d;
   logic [7:0]  ctrl;
   logic        acc_en, acc_clr, hist_bit;
   logic [4:0]  rot_amt;

   assign a        = in_flat[31:0];
   assign b        = in_flat[63:32];
   assign c        = in_flat[95:64];
   assign d        = in_flat[127:96];
   assign ctrl     = in_flat[135:128];
   assign acc_en   = ctrl[0];
   assign acc_clr  = ctrl[1];
   assign rot_amt  = ctrl[6:2];
   assign hist_bit = ctrl[7];

   logic [32:0] sum_d, sum_q;
   logic [32:0] diff_d, diff_q;
   logic [31:0] acc_d, acc_q;
   logic [31:0] rot_d, rot_q;
   logic [15:0] cnt_d, cnt_q;
   logic [5:0]  pop_d, pop_q;
   logic        eq_d, eq_q;
   logic        par_d, par_q;
   logic        ovf_d, ovf_q;
   logic [3:0]  hist_d, hist_q;

   logic [32:0] acc_sum;
   logic [63:0] rot_wide;

   always_comb begin
      sum_d    = {1'b0, a} + {1'b0, b};
      diff_d   = {c[31], c} - {d[31], d};
      // Upper half of the doubled word shifted left is the left rotation.
      rot_wide = {b, b} << rot_amt;
      rot_d    = rot_wide[63:32];
      cnt_d    = cnt_q + 16'd1;
      eq_d     = (a == b);
      par_d    = ^in_flat;
      hist_d   = {hist_q[2:0], hist_bit};

      pop_d = 6'd0;
      for (int i = 0; i < 32; i++) begin
         pop_d = pop_d + {5'd0, d[i]};
      end

      acc_sum = {1'b0, acc_q} + {1'b0, a ^ c};
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      if (acc_clr) begin
         acc_d = 32'd0;
         ovf_d = 1'b0;
      end else if (acc_en) begin
`ifdef ACC_SAT_EN
         acc_d = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
`else
         acc_d = acc_sum[31:0];
`endif
         ovf_d = ovf_q | acc_sum[32];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         diff_q <= '0;
         acc_q  <= '0;
         rot_q  <= '0;
         cnt_q  <= '0;
         pop_q  <= '0;
         eq_q   <= 1'b0;
         par_q  <= 1'b0;
         ovf_q  <= 1'b0;
         hist_q <= '0;
      end else begin
         sum_q  <= sum_d;
         diff_q <= diff_d;
         acc_q  <= acc_d;
         rot_q  <= rot_d;
         cnt_q  <= cnt_d;
         pop_q  <= pop_d;
         eq_q   <= eq_d;
         par_q  <= par_d;
         ovf_q  <= ovf_d;
         hist_q <= hist_d;
      end
   end

   assign out_flat = {hist_q, ovf_q, par_q, eq_q, pop_q, cnt_q, rot_q, acc_q, diff_q, sum_q};

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: constant vectors, hand sequences and random stimulus vs a model.
module tb_top;

   logic         clk;
   logic         rst_n;
   logic [135:0] in_flat;
   logic [158:0] out_flat;

   int pass_cnt = 0;
   int total    = 0;

   top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_flat (in_flat),
      .out_flat(out_flat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0]  m_acc;
   logic         m_ovf;
   logic [3:0]   m_hist;
   logic [15:0]  m_cnt;
   logic [158:0] exp_out;

   typedef struct {
      logic [31:0] a, b, c, d;
      logic [7:0]  ctrl;
      logic [32:0] sum, diff;
      logic [31:0] rot;
      logic [5:0]  pop;
      logic        eq;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [158:0] act, input logic [158:0] req);
      total++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic model_reset();
      m_acc  = '0;
      m_ovf  = 1'b0;
      m_hist = '0;
      m_cnt  = '0;
   endtask

   // Applies the rules of one clock edge to the model and forms the expected output word.
   task automatic model_edge(input logic [135:0] in);
      logic [31:0] a, b, c, d;
      logic [7:0]  ctrl;
      logic [63:0] s, x, r64;
      longint      dv;
      logic [32:0] diff, sum;
      logic [31:0] rot;
      int          r;
      logic        par;
      a    = in[31:0];
      b    = in[63:32];
      c    = in[95:64];
      d    = in[127:96];
      ctrl = in[135:128];
      s    = {32'd0, a} + {32'd0, b};
      sum  = s[32:0];
      dv   = longint'($signed(c)) - longint'($signed(d));
      diff = dv[32:0];
      r    = int'(ctrl[6:2]);
      x    = {32'd0, b};
      r64  = (x << r) | (x >> (32 - r));
      rot  = r64[31:0];
      par  = ($countones(in) % 2) == 1;
      if (ctrl[1]) begin
         m_acc = 0;
         m_ovf = 0;
      end else if (ctrl[0]) begin
         s = {32'd0, m_acc} + {32'd0, a ^ c};
         if (s > 64'hFFFF_FFFF) m_ovf = 1'b1;
`ifdef ACC_SAT_EN
         m_acc = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
         m_acc = s[31:0];
`endif
      end
      m_hist  = {m_hist[2:0], ctrl[7]};
      m_cnt   = m_cnt + 1;
      exp_out = {m_hist, m_ovf, par, a == b, 6'($countones(d)), m_cnt, rot, m_acc, diff, sum};
   endtask

   task automatic step(input logic [135:0] in);
      in_flat = in;
      @(posedge clk);
      model_edge(in);
      #1;
   endtask

   function automatic logic [135:0] pack(input logic [7:0] ctrl, input logic [31:0] d,
                                         input logic [31:0] c, input logic [31:0] b,
                                         input logic [31:0] a);
      return {ctrl, d, c, b, a};
   endfunction

   function automatic logic [135:0] rnd_in();
      return {8'($urandom), $urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [31:0] acc2_exp;

   initial begin
      vecs[0] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 8'h00,
                  33'h1_0000_0000, 33'h1_FFFF_FFFF, 32'h1, 6'd1, 1'b0};
      vecs[1] = '{32'h1234, 32'h1234, 32'h5, 32'h3, 8'h04,
                  33'h2468, 33'h2, 32'h2468, 6'd2, 1'b1};
      vecs[2] = '{32'h0, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 8'h04,
                  33'h8000_0001, 33'h1, 32'h3, 6'd32, 1'b0};
      vecs[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0, 8'h00,
                  33'h1_BD5B_7DDE, 33'h1_8000_0000, 32'hDEAD_BEEF, 6'd0, 1'b1};
      vecs[4] = '{32'h1, 32'h1234_5678, 32'h7FFF_FFFF, 32'h8000_0000, 8'h7C,
                  33'h1234_5679, 33'h0_FFFF_FFFF, 32'h091A_2B3C, 6'd1, 1'b0};

      // Reset: outputs clear asynchronously and stay clear across edges.
      rst_n   = 1'b1;
      in_flat = rnd_in();
      #2 rst_n = 1'b0;
      #1 chk("reset_async", out_flat, '0);
      for (int i = 0; i < 2; i++) begin
         in_flat = rnd_in();
         @(posedge clk);
         #1 chk("reset_hold", out_flat, '0);
      end
      model_reset();
      rst_n = 1'b1;

      // CNT counts 1,2,3 after release and wraps to 0 after 65536 edges.
      for (int i = 1; i <= 65536; i++) begin
         step(pack(8'h00, 32'h0, 32'h0, 32'h0, 32'h0));
         if (i <= 3) chk($sformatf("cnt_%0d", i), 159'(out_flat[145:130]), 159'(i));
      end
      chk("cnt_wrap", 159'(out_flat[145:130]), 159'(0));
      chk("cnt_wrap_model", out_flat, exp_out);

      // Constant vectors for the stateless fields.
      foreach (vecs[i]) begin
         step(pack(vecs[i].ctrl, vecs[i].d, vecs[i].c, vecs[i].b, vecs[i].a));
         chk($sformatf("v%0d_sum", i), 159'(out_flat[32:0]), 159'(vecs[i].sum));
         chk($sformatf("v%0d_diff", i), 159'(out_flat[65:33]), 159'(vecs[i].diff));
         chk($sformatf("v%0d_rot", i), 159'(out_flat[129:98]), 159'(vecs[i].rot));
         chk($sformatf("v%0d_pop", i), 159'(out_flat[151:146]), 159'(vecs[i].pop));
         chk($sformatf("v%0d_eq", i), 159'(out_flat[152]), 159'(vecs[i].eq));
         chk($sformatf("v%0d_model", i), out_flat, exp_out);
      end

      // Accumulator overflow sequence, then clear with en set at the same time.
`ifdef ACC_SAT_EN
      acc2_exp = 32'hFFFF_FFFF;
`else
      acc2_exp = 32'hFFFF_FFE0;
`endif
      step(pack(8'h02, 32'h0, 32'h0, 32'h0, 32'h0));
      chk("acc_clr", 159'({out_flat[154], out_flat[97:66]}), 159'(0));
      step(pack(8'h01, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF0));
      chk("acc_first", 159'({out_flat[154], out_flat[97:66]}), 159'({1'b0, 32'hFFFF_FFF0}));
      step(pack(8'h01, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF0));
      chk("acc_second", 159'({out_flat[154], out_flat[97:66]}), 159'({1'b1, acc2_exp}));
      step(pack(8'h00, 32'h0, 32'h0, 32'h0, 32'h5));
      chk("acc_hold", 159'({out_flat[154], out_flat[97:66]}), 159'({1'b1, acc2_exp}));
      step(pack(8'h03, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF0));
      chk("acc_clr_en", 159'({out_flat[154], out_flat[97:66]}), 159'(0));

      // HIST shift sequence 1,0,1,1.
      step(pack(8'h80, 32'h0, 32'h0, 32'h0, 32'h0));
      step(pack(8'h00, 32'h0, 32'h0, 32'h0, 32'h0));
      step(pack(8'h80, 32'h0, 32'h0, 32'h0, 32'h0));
      step(pack(8'h80, 32'h0, 32'h0, 32'h0, 32'h0));
      chk("hist", 159'(out_flat[158:155]), 159'(4'b1011));
      chk("hist_model", out_flat, exp_out);

      // Random stimulus against the model.
      for (int i = 0; i < 300; i++) begin
         step(rnd_in());
         chk($sformatf("rand_%0d", i), out_flat, exp_out);
      end

      // Reset in mid-operation discards all state.
      #2 rst_n = 1'b0;
      #1 chk("midreset_async", out_flat, '0);
      in_flat = rnd_in();
      @(posedge clk);
      #1 chk("midreset_hold", out_flat, '0);
      model_reset();
      rst_n = 1'b1;
      step(rnd_in());
      chk("midreset_cnt", 159'(out_flat[145:130]), 159'(1));
      chk("midreset_model", out_flat, exp_out);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
